// File: rtl/ipdom_pkg.sv
// Shared defaults, derived widths and record types for the multi-warp IPDOM
// reconvergence stack.
package ipdom_pkg;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_DEPTH     = 8;
  localparam int unsigned DEF_NUM_WARPS = 4;

  // Warp-id width never collapses to zero bits, even for a single warp.
  function automatic int unsigned widx_of(input int unsigned num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

  localparam int unsigned WIDX = widx_of(DEF_NUM_WARPS);
  localparam int unsigned PTRW = $clog2(DEF_DEPTH) + 1;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] join_v;
    logic [DEF_WIDTH-1:0] else_v;
  } ipdom_entry_t;

  typedef struct packed {
    logic [WIDX-1:0]      wid;
    logic [DEF_WIDTH-1:0] data;
    logic                 is_join;
  } ipdom_rsp_t;

endpackage

// File: rtl/VX_dp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Contents are never reset.
module VX_dp_ram #(
  parameter int unsigned DATAW = 1,
  parameter int unsigned SIZE  = 2,
  parameter int unsigned ADDRW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             clk,
  input  logic             write,
  input  logic [ADDRW-1:0] waddr,
  input  logic [DATAW-1:0] wdata,
  input  logic             read,
  input  logic [ADDRW-1:0] raddr,
  output logic [DATAW-1:0] rdata
);

  logic [DATAW-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (write) begin
      mem[waddr] <= wdata;
    end
    if (read) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ipdom_stack_mw.sv
// Multi-warp IPDOM reconvergence stack: per-warp {else, join} stacks sharing one
// dual-port RAM, with a two-stage registered pop response and error pulses.
module ipdom_stack_mw
  import ipdom_pkg::*;
#(
  parameter  int unsigned WIDTH     = DEF_WIDTH,
  parameter  int unsigned DEPTH     = DEF_DEPTH,
  parameter  int unsigned NUM_WARPS = DEF_NUM_WARPS,
  localparam int unsigned WID_W     = widx_of(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push_valid,
  input  logic [WID_W-1:0]     push_wid,
  input  logic [WIDTH-1:0]     push_else,
  input  logic [WIDTH-1:0]     push_join,
  input  logic                 pop_valid,
  input  logic [WID_W-1:0]     pop_wid,
  output logic                 rsp_valid,
  output logic [WID_W-1:0]     rsp_wid,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rsp_is_join,
  output logic [NUM_WARPS-1:0] empty,
  output logic [NUM_WARPS-1:0] full,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic                 err_conflict
);

  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
  localparam int unsigned ROWS  = NUM_WARPS * DEPTH;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [PTR_W-1:0]   count [NUM_WARPS];
  logic [ROWS-1:0]    part;

  logic [PTR_W-1:0]   push_cnt;
  logic [PTR_W-1:0]   pop_cnt;
  logic               push_legal;
  logic               pop_legal;
  logic               push_req;
  logic               pop_req;
  logic               conflict;
  logic               overflow;
  logic               underflow;
  logic               push_acc;
  logic               pop_acc;
  logic               pop_part;
  logic [ROW_W-1:0]   wrow;
  logic [ROW_W-1:0]   rrow;

  logic               s1_valid;
  logic [WID_W-1:0]   s1_wid;
  logic               s1_join;
  logic [2*WIDTH-1:0] ram_rdata;

  always_comb begin
    empty = '0;
    full  = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      empty[w] = (count[w] == '0);
      full[w]  = (count[w] == PTR_W'(DEPTH));
    end
  end

  always_comb begin
    push_cnt = '0;
    pop_cnt  = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (push_wid == WID_W'(w)) push_cnt = count[w];
      if (pop_wid == WID_W'(w))  pop_cnt  = count[w];
    end

    push_legal = (32'(push_wid) < NUM_WARPS);
    pop_legal  = (32'(pop_wid) < NUM_WARPS);
    push_req   = push_valid && push_legal;
    pop_req    = pop_valid && pop_legal;

    // Same-warp collision: the push wins, the pop is dropped regardless of fullness.
    conflict   = push_req && pop_req && (push_wid == pop_wid);
    overflow   = push_req && (push_cnt == PTR_W'(DEPTH));
    push_acc   = push_req && !overflow;
    underflow  = pop_req && !conflict && (pop_cnt == '0);
    pop_acc    = pop_req && !conflict && (pop_cnt != '0);

    wrow     = ROW_W'(32'(push_wid) * DEPTH + 32'(push_cnt));
    rrow     = ROW_W'(32'(pop_wid) * DEPTH + 32'(pop_cnt) - 32'd1);
    pop_part = part[rrow];
  end

  VX_dp_ram #(
    .DATAW (2 * WIDTH),
    .SIZE  (ROWS),
    .ADDRW (ROW_W)
  ) ram (
    .clk   (clk),
    .write (push_acc),
    .waddr (wrow),
    .wdata ({push_join, push_else}),
    .read  (pop_acc),
    .raddr (rrow),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        count[w] <= '0;
      end
      part          <= '0;
      s1_valid      <= 1'b0;
      s1_wid        <= '0;
      s1_join       <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_wid       <= '0;
      rsp_data      <= '0;
      rsp_is_join   <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_conflict  <= 1'b0;
    end else begin
      // Accepted push and pop always target different warps, hence different rows.
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        if (push_acc && push_wid == WID_W'(w)) begin
          count[w] <= count[w] + 1'b1;
        end else if (pop_acc && pop_part && pop_wid == WID_W'(w)) begin
          count[w] <= count[w] - 1'b1;
        end
      end
      if (push_acc) begin
        part[wrow] <= 1'b0;
      end
      if (pop_acc && !pop_part) begin
        part[rrow] <= 1'b1;
      end

      s1_valid <= pop_acc;
      s1_wid   <= pop_wid;
      s1_join  <= pop_part;

      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_wid     <= s1_wid;
        rsp_is_join <= s1_join;
        rsp_data    <= s1_join ? ram_rdata[2*WIDTH-1:WIDTH] : ram_rdata[WIDTH-1:0];
      end

      err_overflow  <= overflow;
      err_underflow <= underflow;
      err_conflict  <= conflict;
    end
  end

  wid_range_a: assert property (@(posedge clk) disable iff (!reset_n)
    (push_valid -> push_legal) && (pop_valid -> pop_legal));

endmodule

// File: tb/tb_ipdom_stack_mw.sv
// Directed bench for ipdom_stack_mw: a vector table for single-cycle behaviour
// plus hand-written overflow-drain and reset-during-pop sequences.
module tb_ipdom_stack_mw;
  import ipdom_pkg::*;

  localparam int unsigned W  = DEF_WIDTH;
  localparam int unsigned D  = DEF_DEPTH;
  localparam int unsigned NW = DEF_NUM_WARPS;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            push_valid;
  logic [WIDX-1:0] push_wid;
  logic [W-1:0]    push_else;
  logic [W-1:0]    push_join;
  logic            pop_valid;
  logic [WIDX-1:0] pop_wid;
  logic            rsp_valid;
  logic [WIDX-1:0] rsp_wid;
  logic [W-1:0]    rsp_data;
  logic            rsp_is_join;
  logic [NW-1:0]   empty;
  logic [NW-1:0]   full;
  logic            err_overflow;
  logic            err_underflow;
  logic            err_conflict;

  always #5 clk = ~clk;

  ipdom_stack_mw #(
    .WIDTH     (W),
    .DEPTH     (D),
    .NUM_WARPS (NW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .push_valid    (push_valid),
    .push_wid      (push_wid),
    .push_else     (push_else),
    .push_join     (push_join),
    .pop_valid     (pop_valid),
    .pop_wid       (pop_wid),
    .rsp_valid     (rsp_valid),
    .rsp_wid       (rsp_wid),
    .rsp_data      (rsp_data),
    .rsp_is_join   (rsp_is_join),
    .empty         (empty),
    .full          (full),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_conflict  (err_conflict)
  );

  // Each row is one cycle; rsp columns hold the response to the previous row's pop.
  typedef struct {
    logic            pv;
    logic [WIDX-1:0] pw;
    ipdom_entry_t    ent;
    logic            qv;
    logic [WIDX-1:0] qw;
    logic            rv;
    ipdom_rsp_t      rsp;
    logic [NW-1:0]   emp;
    logic [NW-1:0]   ful;
    logic [2:0]      err;
  } vec_t;

  vec_t tbl[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  function automatic vec_t mk(input logic pv, input logic [WIDX-1:0] pw,
                              input logic [W-1:0] pe, input logic [W-1:0] pj,
                              input logic qv, input logic [WIDX-1:0] qw,
                              input logic rv, input logic [WIDX-1:0] rw,
                              input logic [W-1:0] rd, input logic rj,
                              input logic [NW-1:0] emp, input logic [2:0] err);
    vec_t v;
    v.pv = pv; v.pw = pw; v.ent.else_v = pe; v.ent.join_v = pj;
    v.qv = qv; v.qw = qw;
    v.rv = rv; v.rsp.wid = rw; v.rsp.data = rd; v.rsp.is_join = rj;
    v.emp = emp; v.ful = '0; v.err = err;
    return v;
  endfunction

  task automatic drive(input logic pv, input logic [WIDX-1:0] pw, input logic [W-1:0] pe,
                       input logic [W-1:0] pj, input logic qv, input logic [WIDX-1:0] qw);
    push_valid = pv; push_wid = pw; push_else = pe; push_join = pj;
    pop_valid = qv; pop_wid = qw;
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string name, input logic ev, input logic [WIDX-1:0] ew,
                           input logic [W-1:0] ed, input logic ej);
    n_vec++;
    if (rsp_valid !== ev || (ev && (rsp_wid !== ew || rsp_data !== ed || rsp_is_join !== ej))) begin
      n_bad++;
      $display("FAIL %s rsp: got v=%0b w=%0d d=%h j=%0b, want v=%0b w=%0d d=%h j=%0b",
               name, rsp_valid, rsp_wid, rsp_data, rsp_is_join, ev, ew, ed, ej);
    end
  endtask

  task automatic check_flags(input string name, input logic [NW-1:0] emp,
                             input logic [NW-1:0] ful, input logic [2:0] err);
    n_vec++;
    if (empty !== emp || full !== ful || {err_overflow, err_underflow, err_conflict} !== err) begin
      n_bad++;
      $display("FAIL %s flags: got empty=%b full=%b ovf/unf/cnf=%b, want empty=%b full=%b ovf/unf/cnf=%b",
               name, empty, full, {err_overflow, err_underflow, err_conflict}, emp, ful, err);
    end
  endtask

  initial begin
    logic [W-1:0] exp_d;
    int unsigned  e;

    reset_n = 1'b0;
    drive(0, 0, '0, '0, 0, 0);
    drive(0, 0, '0, '0, 0, 0);
    check_flags("reset", 4'hF, 4'h0, 3'b000);
    check_rsp("reset", 0, 0, '0, 0);
    reset_n = 1'b1;

    // underflow on reset state
    tbl.push_back(mk(0,0,32'h0,32'h0,     1,0, 0,0,32'h0,0,   4'hF, 3'b010));
    // single entry else/join then underflow
    tbl.push_back(mk(1,1,32'hA5,32'h3C,   0,0, 0,0,32'h0,0,   4'hD, 3'b000));
    tbl.push_back(mk(0,0,32'h0,32'h0,     1,1, 0,0,32'h0,0,   4'hD, 3'b000));
    tbl.push_back(mk(0,0,32'h0,32'h0,     1,1, 1,1,32'hA5,0,  4'hF, 3'b000));
    tbl.push_back(mk(0,0,32'h0,32'h0,     1,1, 1,1,32'h3C,1,  4'hF, 3'b010));
    tbl.push_back(mk(0,0,32'h0,32'h0,     0,0, 0,0,32'h0,0,   4'hF, 3'b000));
    // nested LIFO, pop right after push
    tbl.push_back(mk(1,0,32'hE1,32'hF1,   0,0, 0,0,32'h0,0,   4'hE, 3'b000));
    tbl.push_back(mk(1,0,32'hE2,32'hF2,   0,0, 0,0,32'h0,0,   4'hE, 3'b000));
    tbl.push_back(mk(0,0,32'h0,32'h0,     1,0, 0,0,32'h0,0,   4'hE, 3'b000));
    tbl.push_back(mk(0,0,32'h0,32'h0,     1,0, 1,0,32'hE2,0,  4'hE, 3'b000));
    tbl.push_back(mk(0,0,32'h0,32'h0,     1,0, 1,0,32'hF2,1,  4'hE, 3'b000));
    tbl.push_back(mk(0,0,32'h0,32'h0,     1,0, 1,0,32'hE1,0,  4'hF, 3'b000));
    tbl.push_back(mk(0,0,32'h0,32'h0,     0,0, 1,0,32'hF1,1,  4'hF, 3'b000));
    // cross-warp push/pop, then same-warp conflict
    tbl.push_back(mk(1,3,32'hE7,32'hF7,   0,0, 0,0,32'h0,0,   4'h7, 3'b000));
    tbl.push_back(mk(1,0,32'hA0,32'hB0,   1,3, 0,0,32'h0,0,   4'h6, 3'b000));
    tbl.push_back(mk(0,0,32'h0,32'h0,     0,0, 1,3,32'hE7,0,  4'h6, 3'b000));
    tbl.push_back(mk(1,0,32'hA1,32'hB1,   1,0, 0,0,32'h0,0,   4'h6, 3'b001));
    tbl.push_back(mk(0,0,32'h0,32'h0,     0,0, 0,0,32'h0,0,   4'h6, 3'b000));
    tbl.push_back(mk(0,0,32'h0,32'h0,     1,0, 0,0,32'h0,0,   4'h6, 3'b000));
    tbl.push_back(mk(0,0,32'h0,32'h0,     1,3, 1,0,32'hA1,0,  4'hE, 3'b000));
    tbl.push_back(mk(0,0,32'h0,32'h0,     1,0, 1,3,32'hF7,1,  4'hE, 3'b000));
    tbl.push_back(mk(0,0,32'h0,32'h0,     1,0, 1,0,32'hB1,1,  4'hE, 3'b000));
    tbl.push_back(mk(0,0,32'h0,32'h0,     1,0, 1,0,32'hA0,0,  4'hF, 3'b000));
    tbl.push_back(mk(0,0,32'h0,32'h0,     0,0, 1,0,32'hB0,1,  4'hF, 3'b000));

    foreach (tbl[i]) begin
      drive(tbl[i].pv, tbl[i].pw, tbl[i].ent.else_v, tbl[i].ent.join_v, tbl[i].qv, tbl[i].qw);
      check_flags($sformatf("row%0d", i), tbl[i].emp, tbl[i].ful, tbl[i].err);
      check_rsp($sformatf("row%0d", i), tbl[i].rv, tbl[i].rsp.wid, tbl[i].rsp.data, tbl[i].rsp.is_join);
    end

    // fill warp 2 to DEPTH, overflow once, then drain 2*DEPTH responses
    for (int unsigned i = 0; i < D; i++) begin
      drive(1, 2, 32'(32'h200 + i), 32'(32'h300 + i), 0, 0);
      check_flags($sformatf("fill%0d", i), 4'hB, (i == D - 1) ? 4'h4 : 4'h0, 3'b000);
    end
    drive(1, 2, 32'hDEAD, 32'hBEEF, 0, 0);
    check_flags("overflow", 4'hB, 4'h4, 3'b100);
    for (int unsigned k = 0; k <= 2 * D; k++) begin
      if (k < 2 * D) drive(0, 0, '0, '0, 1, 2);
      else           drive(0, 0, '0, '0, 0, 0);
      if (k > 0) begin
        e = D - 1 - (k - 1) / 2;
        exp_d = ((k - 1) % 2 == 1) ? 32'(32'h300 + e) : 32'(32'h200 + e);
        check_rsp($sformatf("drain%0d", k - 1), 1, 2, exp_d, 1'((k - 1) % 2));
      end
    end
    check_flags("drained", 4'hF, 4'h0, 3'b000);

    // reset asserted right after an accepted pop
    drive(1, 0, 32'hC0, 32'hD0, 0, 0);
    drive(0, 0, '0, '0, 1, 0);
    reset_n = 1'b0;
    drive(0, 0, '0, '0, 0, 0);
    check_rsp("rst_pop0", 0, 0, '0, 0);
    check_flags("rst_pop0", 4'hF, 4'h0, 3'b000);
    drive(0, 0, '0, '0, 0, 0);
    check_rsp("rst_pop1", 0, 0, '0, 0);
    reset_n = 1'b1;
    drive(1, 0, 32'hC1, 32'hD1, 0, 0);
    check_flags("post_rst_push", 4'hE, 4'h0, 3'b000);
    drive(0, 0, '0, '0, 1, 0);
    drive(0, 0, '0, '0, 1, 0);
    check_rsp("post_rst_else", 1, 0, 32'hC1, 0);
    drive(0, 0, '0, '0, 0, 0);
    check_rsp("post_rst_join", 1, 0, 32'hD1, 1);
    check_flags("post_rst_end", 4'hF, 4'h0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
